n4_serial_tx_ctrl: RTL and testbench
====================================

Name: n4_serial_tx_ctrl

Overview:
Controller that sequences a 4-bit left-shift register to serialize parallel nibbles onto a single line. Frame format: start bit (0), 4 data bits MSB first, stop bit (1). Accepts data through a valid/ready handshake, paces each bit over BIT_CYCLES clocks, and drives the register's load/shift/hold selection. Sits between a parallel producer and a serial line, wherever a nibble must leave the chip on one wire.

Parameters:
BIT_CYCLES, 2, clocks per serial bit; legal range >= 1; BIT_CYCLES=1 gives one bit per clock.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock
x3_x0  input  4  parallel data nibble; x3_x0[3] is transmitted first
in_valid  input  1  producer has a nibble on x3_x0
in_ready  output  1  controller can accept a nibble (high only in IDLE)
txd  output  1  serial line; idles at 1
busy  output  1  frame in progress (START, DATA or STOP)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset: on any rising edge with reset=1, the block enters IDLE. Reset values: txd=1, busy=0, done=0, in_ready=1. The shift register and counters clear to 0.
- Reset priority: reset overrides in_valid and every in-flight frame. A frame cut mid-transmission is abandoned, with no done pulse. txd returns to 1 on that same edge.
- Acceptance: a transfer occurs on an edge where reset=0, in_ready=1 and in_valid=1. Data is captured from x3_x0 on that edge.
- Output timing: all outputs are registered or decoded from state only. No combinational path exists from in_valid to in_ready.
- IDLE: txd=1, in_ready=1, busy=0. On acceptance, load the register with x3_x0, clear the tick and bit counters, and go to START.
- START: txd=0 for BIT_CYCLES cycles, then go to DATA with bit counter = 0.
- DATA: txd = register bit 3, held for BIT_CYCLES cycles. At the end of each bit period, shift the register left with 0 fill and increment the bit counter. After the 4th bit (bit counter = 3 at period end), go to STOP.
- STOP: txd=1 for BIT_CYCLES cycles, then return to IDLE. done=1 in the first IDLE cycle (one cycle only).
- Register control: the register holds in every cycle that is not a load or a period-end shift. The controller owns its enable; the register never reloads spontaneously.
- Latency: the first start-bit cycle is the cycle after acceptance. A frame occupies exactly 6*BIT_CYCLES cycles. in_ready returns 1 in the cycle after STOP ends.
- Back-to-back: if in_valid is held high, the next nibble is accepted in that first IDLE cycle, which is also the done cycle. The line then shows one idle (1) cycle between the stop bit and the next start bit.
- in_valid while busy: ignored. x3_x0 may change freely after acceptance.
- Counter widths: tick counter counts 0..BIT_CYCLES-1 and is wide enough for BIT_CYCLES-1 (minimum 1 bit). Bit counter is 2 bits and never wraps inside a frame.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared include file holds:
  - state encodings (IDLE, START, DATA, STOP);
  - the frame constants (start level 0, stop/idle level 1, 4 data bits);
  - the register op codes (HOLD, LOAD, SHIFT).
- One sub-module, n4_shift_datapath: a 4-bit register with a 2-bit op select (HOLD/LOAD/SHIFT-left, 0 fill) and synchronous clear. It exposes bit 3.
- The controller FSM and counters live in n4_serial_tx_ctrl.

Test Plan:
- Reset check: assert reset 3 cycles with in_valid=1 and x3_x0=4'b1111 -> no acceptance; txd=1, in_ready=1, busy=0, done=0 after the reset edge.
- Basic frame, BIT_CYCLES=2: accept 4'b1011 -> txd = 0,0,1,1,0,0,1,1,1,1,1,1 over 12 cycles. busy=1 for those 12 cycles, then done=1 for 1 cycle with in_ready=1.
- Back-to-back, BIT_CYCLES=2: in_valid held high with 4'b0110, then 4'b1001 -> second frame accepted in the done cycle. Expected txd after frame 1's stop: 1 (idle), then 0,0,1,1,0,0,0,0,1,1,1,1.
- Busy-time input: pulse in_valid with 4'b0000 during DATA of frame 4'b1100 -> ignored; frame bits unchanged; no extra frame.
- Mid-frame reset: assert reset during the 2nd data bit -> txd=1, busy=0, in_ready=1 after that edge; no done pulse.
- BIT_CYCLES=1: accept 4'b1000 -> txd = 0,1,0,0,0,1 over 6 cycles; done in the 7th cycle.

Source files
------------

// File: rtl/n4_serial_tx_ctrl_pkg.sv
// Shared constants for the nibble serializer: FSM states, frame levels
// and shift-register op codes.
package n4_serial_tx_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam int   DATA_BITS   = 4;

   localparam logic [1:0] OP_HOLD  = 2'd0;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_SHIFT = 2'd2;

endpackage

// File: rtl/n4_shift_datapath.sv
// 4-bit left-shift register with hold/load/shift select and sync clear.
// Only the MSB leaves the block; it is the bit currently on the line.
module n4_shift_datapath
   import n4_serial_tx_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic [1:0] op,
   input  logic [3:0] din,
   output logic       msb
);

   logic [3:0] q;

   always_ff @(posedge clock) begin
      if (clear) begin
         q <= 4'd0;
      end else begin
         case (op)
            OP_LOAD:  q <= din;
            OP_SHIFT: q <= {q[2:0], 1'b0};
            default:  q <= q;
         endcase
      end
   end

   assign msb = q[3];

endmodule

// File: rtl/n4_serial_tx_ctrl.sv
// Frame sequencer: start(0), 4 data bits MSB first, stop(1), each bit
// held BIT_CYCLES clocks; accepts nibbles over valid/ready in IDLE only.
module n4_serial_tx_ctrl
   import n4_serial_tx_ctrl_pkg::*;
#(
   parameter int BIT_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] x3_x0,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_CYCLES - 1);
   localparam logic [1:0]    BIT_LAST  = 2'(DATA_BITS - 1);

   logic [1:0]    state;
   logic [TW-1:0] tick;
   logic [1:0]    bit_cnt;
   logic          done_r;
   logic          tick_end;
   logic          accept;
   logic [1:0]    op;
   logic          msb;
   logic          line;

   assign tick_end = (tick == TICK_LAST);
   assign in_ready = (state == ST_IDLE);
   assign accept   = in_ready && in_valid;

   always_comb begin
      op = OP_HOLD;
      if (accept) begin
         op = OP_LOAD;
      end else if (state == ST_DATA && tick_end) begin
         op = OP_SHIFT;
      end
   end

   always_comb begin
      line = STOP_LEVEL;
      case (state)
         ST_START: line = START_LEVEL;
         ST_DATA:  line = msb;
         default:  line = STOP_LEVEL;
      endcase
   end

   n4_shift_datapath u_dp (
      .clock (clock),
      .clear (reset),
      .op    (op),
      .din   (x3_x0),
      .msb   (msb)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         tick    <= '0;
         bit_cnt <= 2'd0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state   <= ST_START;
                  tick    <= '0;
                  bit_cnt <= 2'd0;
               end
            end
            ST_START: begin
               if (tick_end) begin
                  state   <= ST_DATA;
                  tick    <= '0;
                  bit_cnt <= 2'd0;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            ST_DATA: begin
               if (tick_end) begin
                  tick <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     state <= ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 2'd1;
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            ST_STOP: begin
               if (tick_end) begin
                  state  <= ST_IDLE;
                  tick   <= '0;
                  done_r <= 1'b1;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               tick    <= '0;
               bit_cnt <= 2'd0;
            end
         endcase
      end
   end

   assign txd  = line;
   assign busy = (state != ST_IDLE);
   assign done = done_r;

endmodule

// File: tb/tb_n4_serial_tx_ctrl.sv
// Bench for n4_serial_tx_ctrl at BIT_CYCLES=2 and BIT_CYCLES=1, checked
// each cycle against a frame-position model of the serial line.
module tb_n4_serial_tx_ctrl;

   logic       clock = 1'b0;
   logic       rst2, rst1;
   logic       vld2, vld1;
   logic [3:0] dat2, dat1;
   logic       rdy2, txd2, busy2, done2;
   logic       rdy1, txd1, busy1, done1;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clock = ~clock;

   n4_serial_tx_ctrl #(.BIT_CYCLES(2)) dut2 (
      .clock(clock), .reset(rst2), .x3_x0(dat2), .in_valid(vld2),
      .in_ready(rdy2), .txd(txd2), .busy(busy2), .done(done2)
   );

   n4_serial_tx_ctrl #(.BIT_CYCLES(1)) dut1 (
      .clock(clock), .reset(rst1), .x3_x0(dat1), .in_valid(vld1),
      .in_ready(rdy1), .txd(txd1), .busy(busy1), .done(done1)
   );

   // observed {txd, busy, in_ready, done}
   function automatic logic [3:0] obs(input int bc);
      if (bc == 1) return {txd1, busy1, rdy1, done1};
      return {txd2, busy2, rdy2, done2};
   endfunction

   // line level k cycles into a frame: slot 0 start, 1..4 data, 5 stop
   function automatic logic exp_bit(input logic [3:0] nib, input int bc,
                                    input int k);
      int idx;
      idx = k / bc;
      if (idx == 0) return 1'b0;
      if (idx >= 5) return 1'b1;
      return nib[4 - idx];
   endfunction

   task automatic set_in(input int bc, input logic r, input logic v,
                         input logic [3:0] d);
      if (bc == 1) begin
         rst1 = r; vld1 = v; dat1 = d;
      end else begin
         rst2 = r; vld2 = v; dat2 = d;
      end
   endtask

   task automatic expect_idle(input int bc, input string tag);
      logic [3:0] o;
      o = obs(bc);
      n_cmp++;
      if (o !== 4'b1010) begin
         n_bad++;
         $display("FAIL %s bc=%0d: got {txd,busy,rdy,done}=%b want 1010",
                  tag, bc, o);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the done-cycle negedge.
   task automatic run_frame(input int bc, input logic [3:0] nib,
                            input logic hold, input int pulse_at);
      logic [3:0] o, e;
      set_in(bc, 1'b0, 1'b1, nib);
      @(negedge clock);
      for (int k = 0; k < 6 * bc; k++) begin
         o = obs(bc);
         e = {exp_bit(nib, bc, k), 3'b100};
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL frame nib=%b bc=%0d k=%0d: got %b want %b",
                     nib, bc, k, o, e);
         end
         set_in(bc, 1'b0, hold || (k == pulse_at), 4'($urandom));
         @(negedge clock);
      end
      o = obs(bc);
      n_cmp++;
      if (o !== 4'b1011) begin
         n_bad++;
         $display("FAIL done_cycle nib=%b bc=%0d: got %b want 1011",
                  nib, bc, o);
      end
   endtask

   task automatic test_reset();
      set_in(2, 1'b1, 1'b1, 4'hF);
      set_in(1, 1'b1, 1'b1, 4'hF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         expect_idle(2, "reset");
         expect_idle(1, "reset");
      end
      set_in(2, 1'b0, 1'b0, 4'h0);
      set_in(1, 1'b0, 1'b0, 4'h0);
      @(negedge clock);
      expect_idle(2, "post_reset");
      expect_idle(1, "post_reset");
   endtask

   task automatic test_basic();
      run_frame(2, 4'b1011, 1'b0, -1);
      @(negedge clock);
      expect_idle(2, "basic_after");
   endtask

   task automatic test_back_to_back();
      run_frame(2, 4'b0110, 1'b1, -1);
      run_frame(2, 4'b1001, 1'b0, -1);
      @(negedge clock);
      expect_idle(2, "b2b_after");
   endtask

   task automatic test_busy_input();
      run_frame(2, 4'b1100, 1'b0, 4);
      @(negedge clock);
      expect_idle(2, "busy_in_after1");
      @(negedge clock);
      expect_idle(2, "busy_in_after2");
   endtask

   task automatic test_mid_reset();
      logic [3:0] o, e, nib;
      nib = 4'b1010;
      set_in(2, 1'b0, 1'b1, nib);
      @(negedge clock);
      set_in(2, 1'b0, 1'b0, 4'h0);
      for (int k = 0; k <= 4; k++) begin
         o = obs(2);
         e = {exp_bit(nib, 2, k), 3'b100};
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL mid_reset k=%0d: got %b want %b", k, o, e);
         end
         if (k < 4) @(negedge clock);
      end
      set_in(2, 1'b1, 1'b0, 4'h0);
      @(negedge clock);
      expect_idle(2, "mid_reset_edge");
      set_in(2, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         expect_idle(2, "mid_reset_nodone");
      end
   endtask

   task automatic test_bc1();
      run_frame(1, 4'b1000, 1'b0, -1);
      @(negedge clock);
      expect_idle(1, "bc1_after");
   endtask

   task automatic test_random(input int bc);
      int gap;
      for (int f = 0; f < 8; f++) begin
         run_frame(bc, 4'($urandom), 1'b0,
                   int'($urandom_range(0, 6 * bc)) - 1);
         set_in(bc, 1'b0, 1'b0, 4'($urandom));
         gap = int'($urandom_range(1, 3));
         for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            expect_idle(bc, "random_gap");
         end
      end
   endtask

   initial begin
      set_in(2, 1'b1, 1'b0, 4'h0);
      set_in(1, 1'b1, 1'b0, 4'h0);
      test_reset();
      test_basic();
      test_back_to_back();
      test_busy_input();
      test_mid_reset();
      test_bc1();
      test_random(2);
      test_random(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
